// File: rtl/aes_pkg.sv
// Shared AES datapath types, widths and GF(2^8) helpers.
// Used by the sequential (Inv)MixColumns engine and its column datapath.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;
  localparam logic [7:0] AES_GF_RED = 8'h1b;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } imc_state_e;

  // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_GF_RED : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// One AES column through MixColumns or InvMixColumns.
// Coefficients come from x2/x4/x8 xtime chains combined with XOR.
module mix_column_word
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_i,
  input  logic                 inv_i,
  output logic [AES_COL_W-1:0] col_o
);

  logic [7:0] s  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];
  logic [7:0] fw [4];
  logic [7:0] iv [4];

  for (genvar r = 0; r < 4; r++) begin : g_mul
    assign s[r]  = col_i[31-8*r -: 8];
    assign x2[r] = xtime(s[r]);
    assign x4[r] = xtime(x2[r]);
    assign x8[r] = xtime(x4[r]);
    assign m9[r] = x8[r] ^ s[r];
    assign mb[r] = x8[r] ^ x2[r] ^ s[r];
    assign md[r] = x8[r] ^ x4[r] ^ s[r];
    assign me[r] = x8[r] ^ x4[r] ^ x2[r];
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    // Row r sees its own byte first, then the next three cyclically.
    assign fw[r] = x2[r]
                 ^ x2[(r+1)%4] ^ s[(r+1)%4]
                 ^ s[(r+2)%4]
                 ^ s[(r+3)%4];
    assign iv[r] = me[r]
                 ^ mb[(r+1)%4]
                 ^ md[(r+2)%4]
                 ^ m9[(r+3)%4];
    assign col_o[31-8*r -: 8] = inv_i ? iv[r] : fw[r];
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential (Inv)MixColumns: one column per cycle, one shared column unit.
// Accept, four compute cycles, then hold the result until it is taken.
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] state_in,
  input  logic                   inverse,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out
);

  imc_state_e             state_q, state_d;
  logic [1:0]             col_q, col_d;
  logic [AES_STATE_W-1:0] data_q, data_d;
  logic [AES_STATE_W-1:0] res_q, res_d;
  logic                   inv_q, inv_d;

  logic [6:0]             msb;
  logic [AES_COL_W-1:0]   col_in;
  logic [AES_COL_W-1:0]   col_out;

  // Column c occupies bits [127-32c -: 32]; 127-32c == {~c, 5'h1f}.
  assign msb    = {~col_q, 5'h1f};
  assign col_in = data_q[msb -: AES_COL_W];

  mix_column_word u_col (
    .col_i (col_in),
    .inv_i (inv_q),
    .col_o (col_out)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    data_d    = data_q;
    res_d     = res_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = state_in;
          inv_d   = inverse;
          col_d   = 2'd0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        res_d[msb -: AES_COL_W] = col_out;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_out = out_valid ? res_q : '0;

  // State and datapath registers, cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      data_q  <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
    end
  end

endmodule

// File: doc/inv_mix_columns_seq.md
INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

Interface
REQ-001 Parameters SHALL be none; all widths are fixed by the AES-128 state.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  state_in and inverse are valid.
REQ-005 in_ready  output  1  block can accept a state.
REQ-006 state_in  input  128  AES state; column c = bits [127-32c -: 32]; row 0 is the MSB byte of each column.
REQ-007 inverse  input  1  1 = InvMixColumns {0e,0b,0d,09}; 0 = MixColumns {02,03,01,01}; sampled with state_in.
REQ-008 out_valid  output  1  state_out holds a finished result.
REQ-009 out_ready  input  1  consumer accepts state_out.
REQ-010 state_out  output  128  transformed state, same column/row layout as state_in.

Function
REQ-011 FSM states SHALL be IDLE, COMPUTE and DONE.
REQ-012 IDLE: in_ready=1; on in_valid&&in_ready, latch state_in and inverse, clear col counter, go to COMPUTE.
REQ-013 COMPUTE: in_ready=0; each cycle transform column col, write it into the result register at the same column position, col+1.
REQ-014 Column order SHALL be 0,1,2,3; on col==3 go to DONE; col is 2 bits and wraps to 0.
REQ-015 Latency SHALL be fixed: out_valid rises exactly 4 cycles after the accepting edge.
REQ-016 DONE: out_valid=1, in_ready=0; state_out and out_valid SHALL stay stable until out_ready=1, then go to IDLE on that edge.
REQ-017 No overlap: a new input SHALL NOT be accepted in the same cycle an output is consumed; the earliest next accept is one cycle after the output handshake.
REQ-018 in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-019 Changes on state_in or inverse after acceptance SHALL NOT affect the result.
REQ-020 Column math SHALL be GF(2^8) with polynomial 0x11b; xtime(b) = (b<<1) ^ (b[7] ? 0x1b : 0).
REQ-021 Coefficients 09/0b/0d/0e SHALL be built from xtime chains (x2, x4, x8) and XOR; no lookup tables.
REQ-022 Inverse row r of output = 0e*s[r] ^ 0b*s[r+1] ^ 0d*s[r+2] ^ 09*s[r+3], indices mod 4; forward uses 02,03,01,01 in the same rotation.
REQ-023 state_out SHALL read 0 whenever out_valid=0.

Reset
REQ-024 rst SHALL asynchronously force IDLE, col=0, and clear the result, latched state and latched inverse to 0.
REQ-025 After rst: in_ready=1, out_valid=0, state_out=0.
REQ-026 rst asserted in COMPUTE or DONE SHALL abort the operation; no partial result is ever presented.

Structure
REQ-027 Shared package aes_pkg SHALL hold the state enum type, AES_STATE_W=128, AES_COL_W=32 and the constant 8'h1b.
REQ-028 One combinational sub-module, mix_column_word (32-bit column in, inverse select, 32-bit column out), SHALL be instantiated once and time-shared across columns.
REQ-029 The datapath SHALL contain no multipliers other than xtime/XOR networks.

Verification
REQ-030 Inverse, column 8e4da1bc replicated in all 4 columns -> state_out = db135345 x4, out_valid 4 cycles after accept.
REQ-031 Forward, state = db135345_f20a225c_01010101_c6c6c6c6 -> 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-032 Round trip: forward of a random state, then inverse of that result -> original state, over 1000 random states.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles in DONE -> state_out stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-034 Reset mid-COMPUTE at col=2 -> next cycle in_ready=1, out_valid=0, state_out=0; the following input completes correctly.
REQ-035 Input changed on the cycle after accept (state_in=0, inverse flipped) -> result matches the originally latched values.
